// File: rtl/debounce_pkg.sv
// Shared types and defaults for the front-panel input debouncers.
package debounce_pkg;

    typedef enum logic [1:0] {
        REL     = 2'b00,
        ARM_PRS = 2'b01,
        PRS     = 2'b10,
        ARM_REL = 2'b11
    } deb_state_t;

    localparam int DEB_CNT_MAX_DEFAULT     = 500000;
    localparam int DEB_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/button_debouncer_if.sv
// Button path signals: raw input towards the debouncer, clean level/pulses back.
// btn_fall exists only when BUTTON_DEBOUNCER_FALL_PULSE_EN is defined.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic busy;
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
    logic btn_fall;

    modport master (output btn_in, input btn_level, btn_rise, busy, btn_fall);
    modport slave  (input btn_in, output btn_level, btn_rise, busy, btn_fall);
`else
    modport master (output btn_in, input btn_level, btn_rise, busy);
    modport slave  (input btn_in, output btn_level, btn_rise, busy);
`endif
endinterface

// File: rtl/button_debouncer_sync_chain.sv
// Generic multi-flop synchroniser for asynchronous board inputs.
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser + stability-count FSM, clean level and press pulse.
// Optional BUTTON_DEBOUNCER_FALL_PULSE_EN adds a release pulse (btn_fall).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = DEB_SYNC_STAGES_DEFAULT,
    parameter int   CNT_MAX     = DEB_CNT_MAX_DEFAULT,
    parameter int   CNT_W       = 20,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    button_debouncer_if.slave btn
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);

    logic             sync_q;
    logic             s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             busy_q;
    logic             fall_q;

    sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (btn.btn_in),
        .q     (sync_q)
    );

    // Normalise so 1 always means "pressed" regardless of board wiring.
    assign s = sync_q ^ IDLE_LEVEL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= REL;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            busy_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                REL: if (s) begin
                    state  <= ARM_PRS;
                    cnt    <= CNT_W'(1);
                    busy_q <= 1'b1;
                end
                ARM_PRS: begin
                    if (!s) begin
                        state  <= REL;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == LAST) begin
                        state   <= PRS;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        busy_q  <= 1'b0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRS: if (!s) begin
                    state  <= ARM_REL;
                    cnt    <= CNT_W'(1);
                    busy_q <= 1'b1;
                end
                ARM_REL: begin
                    // Level stays asserted until the release is fully qualified.
                    if (s) begin
                        state  <= PRS;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == LAST) begin
                        state   <= REL;
                        cnt     <= '0;
                        level_q <= 1'b0;
                        busy_q  <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= REL;
                    cnt     <= '0;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign btn.btn_level = level_q;
    assign btn.btn_rise  = rise_q;
    assign btn.busy      = busy_q;

`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
    assign btn.btn_fall = fall_q;
`else
    logic unused_fall;
    assign unused_fall = fall_q;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with CNT_MAX=4, SYNC_STAGES=2.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   fails = 0;
    int   rises;
    int   busy_hi;
    logic [7:0] pat;

    always #5 clk = ~clk;

    button_debouncer_if bif();

    button_debouncer #(
        .SYNC_STAGES (2),
        .CNT_MAX     (4),
        .CNT_W       (3),
        .IDLE_LEVEL  (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic lvl, input logic rise, input logic bsy);
        chk({tag, ".level"}, bif.btn_level, lvl);
        chk({tag, ".rise"},  bif.btn_rise,  rise);
        chk({tag, ".busy"},  bif.busy,      bsy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with the button pressed: nothing may leak through.
        reset = 1'b0;
        bif.btn_in = 1'b1;
        #1;
        chk_outs("reset_async", 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            tick();
            chk_outs("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        bif.btn_in = 1'b0;
        reset = 1'b1;
        repeat (4) begin
            tick();
            chk_outs("idle", 1'b0, 1'b0, 1'b0);
        end

        // Clean press, then hold for 100 cycles: one pulse at edge 6.
        bif.btn_in = 1'b1;
        rises = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            rises += int'(bif.btn_rise);
            if (k <= 8) chk_outs("press", k >= 6, k == 6, (k >= 3) && (k <= 5));
        end
        chk("hold_one_rise", rises, 1);
        chk_outs("held", 1'b1, 1'b0, 1'b0);

        // Release: level drops at edge 6, no press pulse.
        bif.btn_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_outs("release", k < 6, 1'b0, (k >= 3) && (k <= 5));
`ifdef BUTTON_DEBOUNCER_FALL_PULSE_EN
            chk("release_fall", bif.btn_fall, k == 6);
`endif
        end

        // Bounce: 1,1,1,0,1,1,1,0 never reaches four stable samples.
        pat = 8'b0111_0111;
        busy_hi = 0;
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            bif.btn_in = (k < 8) ? pat[k] : 1'b0;
            tick();
            busy_hi += int'(bif.busy);
            rises   += int'(bif.btn_rise);
            chk("bounce_level", bif.btn_level, 1'b0);
        end
        chk("bounce_busy_cycles", busy_hi, 6);
        chk("bounce_no_rise", rises, 0);
        chk("bounce_busy_end", bif.busy, 1'b0);

        // Reset while qualifying a press (counter at 2), button kept held.
        bif.btn_in = 1'b1;
        repeat (4) tick();
        chk("arm_busy", bif.busy, 1'b1);
        chk("arm_level", bif.btn_level, 1'b0);
        reset = 1'b0;
        #1;
        chk_outs("midarm_reset", 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            tick();
            chk_outs("midarm_hold", 1'b0, 1'b0, 1'b0);
        end
        #2;
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_outs("requal", k >= 6, k == 6, (k >= 3) && (k <= 5));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
